// File: rtl/i2c_req_arbiter.sv
// Three-requester round-robin arbiter in front of a single I2C master.
// Latches the winner's command, hands it to the master and reports completion back.
module i2c_req_arbiter #(
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic        SYSTEM_CLK,
  input  logic        RESETn,
  input  logic [2:0]  req,
  input  logic [2:0]  req_rw,
  input  logic [23:0] req_addr,
  input  logic [23:0] req_offset,
  input  logic [23:0] req_wdata,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic [2:0]  err,
  output logic [7:0]  rd_data,
  output logic        m_start,
  output logic        m_read,
  output logic        m_write,
  output logic [7:0]  m_address,
  output logic [7:0]  m_offset,
  output logic [7:0]  m_wdata,
  input  logic        m_done,
  input  logic        m_ack_err,
  input  logic [7:0]  m_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_FIN} state_t;

  // Counter value during the last permitted WAIT cycle.
  localparam logic [11:0] TO_LAST = 12'(TIMEOUT_CYC - 1);

  state_t      state, state_nxt;
  logic [1:0]  winner, last_winner, pick;
  logic        rw_q, status;
  logic [11:0] cnt;
  logic [2:0]  winner_oh;
  logic        granted, timeout;

  // Search starts just after the previous winner and wraps modulo 3.
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic       found;
    rr_pick = 2'd0;
    found   = 1'b0;
    idx     = last;
    for (int k = 0; k < 3; k++) begin
      idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      if (r[idx] && !found) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  assign pick      = rr_pick(req, last_winner);
  assign winner_oh = 3'b001 << winner;
  assign granted   = (state == S_START) || (state == S_WAIT);
  assign timeout   = (cnt == TO_LAST);

  // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_START;
      S_START: state_nxt = S_WAIT;
      S_WAIT:  if (m_done || timeout) state_nxt = S_FIN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge SYSTEM_CLK or negedge RESETn) begin
    if (!RESETn) begin
      state       <= S_IDLE;
      winner      <= 2'd0;
      last_winner <= 2'd2;
      rw_q        <= 1'b0;
      status      <= 1'b0;
      cnt         <= '0;
      rd_data     <= 8'h00;
      m_address   <= 8'h00;
      m_offset    <= 8'h00;
      m_wdata     <= 8'h00;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (|req) begin
            winner    <= pick;
            rw_q      <= req_rw[pick];
            m_address <= {req_addr[{pick, 3'b000} + 5'd1 +: 7], req_rw[pick]};
            m_offset  <= req_offset[{pick, 3'b000} +: 8];
            m_wdata   <= req_wdata[{pick, 3'b000} +: 8];
          end
        end
        S_WAIT: begin
          cnt <= cnt + 12'd1;
          // m_done wins over a coincident timeout.
          if (m_done) begin
            status <= m_ack_err;
            if (rw_q && !m_ack_err) rd_data <= m_rdata;
          end else if (timeout) begin
            status <= 1'b1;
          end
        end
        S_FIN:   last_winner <= winner;
        default: ;
      endcase
    end
  end

  assign gnt     = granted ? winner_oh : 3'b000;
  assign done    = (state == S_FIN) ? winner_oh : 3'b000;
  assign err     = (state == S_FIN && status) ? winner_oh : 3'b000;
  assign m_start = (state == S_START);
  assign m_read  = granted && rw_q;
  assign m_write = granted && !rw_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: reset, write, read, round-robin, NACK, timeout, mid-WAIT reset.
module tb_i2c_req_arbiter;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req, req_rw, gnt, done, err;
  logic [23:0] req_addr, req_offset, req_wdata;
  logic [7:0]  rd_data, m_address, m_offset, m_wdata, m_rdata;
  logic        m_start, m_read, m_write, m_done, m_ack_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  i2c_req_arbiter #(.TIMEOUT_CYC(TO)) dut (
    .SYSTEM_CLK (clk),
    .RESETn     (rst_n),
    .req        (req),
    .req_rw     (req_rw),
    .req_addr   (req_addr),
    .req_offset (req_offset),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .rd_data    (rd_data),
    .m_start    (m_start),
    .m_read     (m_read),
    .m_write    (m_write),
    .m_address  (m_address),
    .m_offset   (m_offset),
    .m_wdata    (m_wdata),
    .m_done     (m_done),
    .m_ack_err  (m_ack_err),
    .m_rdata    (m_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_offset = '0; req_wdata = '0;
    m_done = 1'b0; m_ack_err = 1'b0; m_rdata = '0;
    #12;
    n_vec++; if (gnt !== 3'b000) begin n_err++; $display("FAIL rst_gnt: got %b, want 000", gnt); end
    n_vec++; if (done !== 3'b000 || err !== 3'b000) begin n_err++; $display("FAIL rst_done_err: got %b/%b, want 000/000", done, err); end
    n_vec++; if ({m_start, m_read, m_write} !== 3'b000) begin n_err++; $display("FAIL rst_ctl: got %b, want 000", {m_start, m_read, m_write}); end
    n_vec++; if ({rd_data, m_address, m_offset, m_wdata} !== 32'h0) begin n_err++; $display("FAIL rst_fields: got %h, want 00000000", {rd_data, m_address, m_offset, m_wdata}); end
    @(negedge clk); rst_n = 1'b1;
    // m_done while idle must be ignored
    m_done = 1'b1; m_ack_err = 1'b1; tick; tick; m_done = 1'b0; m_ack_err = 1'b0;
    n_vec++; if (gnt !== 3'b000 || done !== 3'b000) begin n_err++; $display("FAIL idle_mdone: got gnt %b done %b, want 000 000", gnt, done); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp;
    req_addr = {8'h30, 8'h20, 8'h10}; req_rw = 3'b000; req = 3'b111;
    tick;
    for (int k = 0; k < 3; k++) begin
      exp = 3'b001 << k;
      n_vec++; if (gnt !== exp || m_start !== 1'b1) begin n_err++; $display("FAIL rr_gnt%0d: got gnt %b start %b, want %b 1", k, gnt, m_start, exp); end
      n_vec++; if (m_address !== 8'(8'h10 * (k + 1))) begin n_err++; $display("FAIL rr_addr%0d: got %h, want %h", k, m_address, 8'(8'h10 * (k + 1))); end
      tick;
      m_done = 1'b1; tick; m_done = 1'b0;
      if (k == 2) req = 3'b000;
      n_vec++; if (done !== exp || gnt !== 3'b000) begin n_err++; $display("FAIL rr_done%0d: got done %b gnt %b, want %b 000", k, done, gnt, exp); end
      tick;
      n_vec++; if (gnt !== 3'b000 || m_start !== 1'b0 || done !== 3'b000) begin n_err++; $display("FAIL rr_idle%0d: got gnt %b start %b done %b, want 000 0 000", k, gnt, m_start, done); end
      if (k < 2) tick;
    end
  endtask

  task automatic test_single_write();
    req_addr[7:0] = 8'h46; req_offset[7:0] = 8'h5A; req_wdata[7:0] = 8'h5A; req_rw = 3'b000; req = 3'b001;
    tick;
    n_vec++; if (gnt !== 3'b001 || m_start !== 1'b1) begin n_err++; $display("FAIL wr_gnt: got gnt %b start %b, want 001 1", gnt, m_start); end
    n_vec++; if (m_address !== 8'h46 || m_offset !== 8'h5A || m_wdata !== 8'h5A) begin n_err++; $display("FAIL wr_fields: got %h %h %h, want 46 5a 5a", m_address, m_offset, m_wdata); end
    n_vec++; if (m_write !== 1'b1 || m_read !== 1'b0) begin n_err++; $display("FAIL wr_dir: got w%b r%b, want w1 r0", m_write, m_read); end
    // dropping req and changing inputs must not disturb the held command
    req = 3'b000; req_addr[7:0] = 8'hFF; req_offset[7:0] = 8'h00;
    tick;
    n_vec++; if (gnt !== 3'b001 || m_start !== 1'b0 || m_address !== 8'h46 || m_offset !== 8'h5A) begin n_err++; $display("FAIL wr_hold: got gnt %b start %b addr %h off %h, want 001 0 46 5a", gnt, m_start, m_address, m_offset); end
    m_done = 1'b1; m_ack_err = 1'b0; tick; m_done = 1'b0;
    n_vec++; if (done !== 3'b001 || err !== 3'b000 || gnt !== 3'b000 || m_write !== 1'b0) begin n_err++; $display("FAIL wr_done: got done %b err %b gnt %b w %b, want 001 000 000 0", done, err, gnt, m_write); end
    tick;
    n_vec++; if (done !== 3'b000) begin n_err++; $display("FAIL wr_done_pulse: got %b, want 000", done); end
  endtask

  task automatic test_single_read();
    req_addr[15:8] = 8'h46; req_rw = 3'b010; req = 3'b010;
    tick;
    n_vec++; if (gnt !== 3'b010 || m_address !== 8'h47 || m_read !== 1'b1 || m_write !== 1'b0) begin n_err++; $display("FAIL rd_gnt: got gnt %b addr %h r%b w%b, want 010 47 r1 w0", gnt, m_address, m_read, m_write); end
    req = 3'b000; tick;
    m_done = 1'b1; m_rdata = 8'hA0; tick; m_done = 1'b0; m_rdata = 8'h00;
    n_vec++; if (done !== 3'b010 || err !== 3'b000 || rd_data !== 8'hA0) begin n_err++; $display("FAIL rd_done: got done %b err %b data %h, want 010 000 a0", done, err, rd_data); end
    tick;
  endtask

  task automatic test_nack();
    req_addr[23:16] = 8'h50; req_rw = 3'b100; req = 3'b100;
    tick;
    n_vec++; if (gnt !== 3'b100 || m_address !== 8'h51) begin n_err++; $display("FAIL nack_gnt: got gnt %b addr %h, want 100 51", gnt, m_address); end
    req = 3'b000; tick;
    m_done = 1'b1; m_ack_err = 1'b1; m_rdata = 8'h55; tick; m_done = 1'b0; m_ack_err = 1'b0;
    n_vec++; if (done !== 3'b100 || err !== 3'b100 || rd_data !== 8'hA0) begin n_err++; $display("FAIL nack_done: got done %b err %b data %h, want 100 100 a0", done, err, rd_data); end
    tick;
    n_vec++; if (err !== 3'b000) begin n_err++; $display("FAIL nack_err_pulse: got %b, want 000", err); end
  endtask

  task automatic test_timeout();
    int  n;
    logic early;
    req_addr[7:0] = 8'h46; req_rw = 3'b001; req = 3'b001; m_rdata = 8'h33;
    tick; req = 3'b000; tick;
    n = 0;
    while (done === 3'b000 && n < 4 * TO) begin tick; n++; end
    n_vec++; if (n !== TO) begin n_err++; $display("FAIL to_cycles: got %0d, want %0d", n, TO); end
    n_vec++; if (done !== 3'b001 || err !== 3'b001 || rd_data !== 8'hA0) begin n_err++; $display("FAIL to_done: got done %b err %b data %h, want 001 001 a0", done, err, rd_data); end
    tick;
    // m_done on the final WAIT cycle beats the timeout
    req_rw = 3'b000; req = 3'b010;
    tick; req = 3'b000; tick;
    early = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      if (done !== 3'b000) early = 1'b1;
      tick;
    end
    n_vec++; if (early !== 1'b0 || done !== 3'b000) begin n_err++; $display("FAIL race_early: got early %b done %b, want 0 000", early, done); end
    m_done = 1'b1; tick; m_done = 1'b0;
    n_vec++; if (done !== 3'b010 || err !== 3'b000) begin n_err++; $display("FAIL race_done: got done %b err %b, want 010 000", done, err); end
    tick;
  endtask

  task automatic test_reset_mid_wait();
    logic seen;
    req_rw = 3'b001; req = 3'b001;
    tick; req = 3'b000; tick;
    n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL mid_pre: got gnt %b, want 001", gnt); end
    rst_n = 1'b0; #1;
    n_vec++; if (gnt !== 3'b000 || {m_start, m_read, m_write} !== 3'b000) begin n_err++; $display("FAIL mid_rst_ctl: got gnt %b ctl %b, want 000 000", gnt, {m_start, m_read, m_write}); end
    n_vec++; if ({rd_data, m_address} !== 16'h0) begin n_err++; $display("FAIL mid_rst_fields: got %h, want 0000", {rd_data, m_address}); end
    tick;
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    m_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (done !== 3'b000 || gnt !== 3'b000) seen = 1'b1;
    end
    m_done = 1'b0;
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL mid_no_done: got activity %b, want 0", seen); end
    req = 3'b111; tick;
    n_vec++; if (gnt !== 3'b001) begin n_err++; $display("FAIL mid_regrant: got %b, want 001", gnt); end
    req = 3'b000;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_write();
    test_single_read();
    test_nack();
    test_timeout();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
